trap_csr: RTL

Machine-mode trap and interrupt CSR unit for the MegaV core, sitting beside the stage FSM in both directions. It consumes the FSM's per-instruction `control_op`/`fault_num` in the control stage and commits trap entry, `mret` and CSR instructions exactly once per control stage. It feeds the FSM's `ext_int`/`sw_int` inputs from enabled, pending interrupts and supplies trap-vector and return PCs to the PC logic.

---
 rtl/trap_csr.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/trap_csr.sv
// trap_csr: machine-mode trap/interrupt CSRs with a once-per-control-stage commit.
// Trap entry outranks mret, which outranks a CSR write, within a single commit.
module trap_csr #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        control_stage,
    input  logic [1:0]  control_op,
    input  logic [2:0]  fault_num,
    input  logic [31:0] pc,
    input  logic [31:0] fault_addr,
    input  logic        ext_irq_in,
    input  logic        mret,
    input  logic        csr_en,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic        ext_int,
    output logic        sw_int,
    output logic [31:0] trap_vector,
    output logic [31:0] mret_pc
);
    typedef enum logic {IDLE, DONE} state_t;
    state_t state_q, state_d;
    logic commit, supported, is_trap, is_mret, is_wr;
    logic [31:0] wr_val;
    logic mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
    logic mie_msie_q, mie_msie_d, mie_meie_q, mie_meie_d;
    logic mip_msip_q, mip_msip_d, mip_meip_q, mip_meip_d;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    // DONE holds for the rest of the occupancy so a long stage commits once
    always_comb state_d = control_stage ? DONE : IDLE;

    always_comb commit = (state_q == IDLE) && control_stage;

    always_comb begin
        supported = 1'b1;
        csr_rdata = '0;
        case (csr_addr)
            12'h300: csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
            12'h304: csr_rdata = {20'b0, mie_meie_q, 7'b0, mie_msie_q, 3'b0};
            12'h305: csr_rdata = mtvec_q;
            12'h340: csr_rdata = mscratch_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h343: csr_rdata = mtval_q;
            12'h344: csr_rdata = {20'b0, mip_meip_q, 7'b0, mip_msip_q, 3'b0};
            default: supported = 1'b0;
        endcase
    end

    always_comb begin
        csr_illegal = csr_en && !supported;
        wr_val = csr_op == 2'b01 ? csr_wdata :
                 csr_op == 2'b10 ? csr_rdata | csr_wdata : csr_rdata & ~csr_wdata;
        is_trap = commit && control_op != 2'b11;
        is_mret = commit && !is_trap && mret;
        is_wr = commit && !is_trap && !mret && csr_en && supported && csr_op != 2'b00;
        ext_int = mstatus_mie_q && mie_meie_q && mip_meip_q;
        sw_int = mstatus_mie_q && mie_msie_q && mip_msip_q;
        trap_vector = mtvec_q;
        mret_pc = mepc_q;
    end

    always_comb begin
        mstatus_mie_d = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_msie_d = mie_msie_q;
        mie_meie_d = mie_meie_q;
        mip_msip_d = mip_msip_q;
        mip_meip_d = ext_irq_in;
        mtvec_d = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d = mepc_q;
        mcause_d = mcause_q;
        mtval_d = mtval_q;
        if (is_trap) begin
            mepc_d = pc & 32'hFFFF_FFFC;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d = 1'b0;
            mcause_d = control_op == 2'b00 ? {29'b0, fault_num} :
                       control_op == 2'b01 ? 32'h8000_000B : 32'h8000_0003;
            // faults 2 and 3 carry no address
            mtval_d = (control_op == 2'b00 && fault_num[2:1] != 2'b01) ? fault_addr : '0;
        end else if (is_mret) begin
            mstatus_mie_d = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (is_wr) begin
            case (csr_addr)
                12'h300: begin
                    mstatus_mie_d = wr_val[3];
                    mstatus_mpie_d = wr_val[7];
                end
                12'h304: begin
                    mie_msie_d = wr_val[3];
                    mie_meie_d = wr_val[11];
                end
                12'h305: mtvec_d = wr_val & 32'hFFFF_FFFC;
                12'h340: mscratch_d = wr_val;
                12'h341: mepc_d = wr_val & 32'hFFFF_FFFC;
                12'h342: mcause_d = wr_val;
                12'h343: mtval_d = wr_val;
                12'h344: mip_msip_d = wr_val[3];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mstatus_mie_q <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_msie_q <= 1'b0;
            mie_meie_q <= 1'b0;
            mip_msip_q <= 1'b0;
            mip_meip_q <= 1'b0;
            mtvec_q <= MTVEC_RESET & 32'hFFFF_FFFC;
            mscratch_q <= '0;
            mepc_q <= '0;
            mcause_q <= '0;
            mtval_q <= '0;
        end else begin
            mstatus_mie_q <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_msie_q <= mie_msie_d;
            mie_meie_q <= mie_meie_d;
            mip_msip_q <= mip_msip_d;
            mip_meip_q <= mip_meip_d;
            mtvec_q <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q <= mepc_d;
            mcause_q <= mcause_d;
            mtval_q <= mtval_d;
        end
    end
endmodule
